// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Avalon-MM slave that sequences an iterative shift-add
//                multiplier. Software loads operands A/B, writes a start
//                command, and the block runs one partial-product step per
//                clock. The product is committed to a held output register
//                (out_port). Busy/done status and an optional interrupt.
//  Options     : define MUL_SEQ_SIGNED_EN to enable the two's-complement
//                (signed_mode) path selected by CTRL bit2.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [2*DATA_W-1:0]   out_port,
    output logic                  busy,
    output logic                  irq
);

    localparam int                PROD_W = 2 * DATA_W;
    localparam int                CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] C_ADDR_A    = 2'd0;
    localparam logic [1:0] C_ADDR_B    = 2'd1;
    localparam logic [1:0] C_ADDR_CTRL = 2'd2;
    localparam logic [1:0] C_ADDR_RES  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DATA_W-1:0]      r_op_a;
    logic [DATA_W-1:0]      r_op_b;
    logic [PROD_W-1:0]      r_acc;
    logic [PROD_W-1:0]      r_mcand;
    logic [DATA_W-1:0]      r_mplier;
    logic [CNT_W-1:0]       r_cnt;
    logic [PROD_W-1:0]      r_result;
    logic                   r_done;
    logic                   r_irq_en;

    logic                   w_wr;
    logic                   w_wr_a;
    logic                   w_wr_b;
    logic                   w_wr_ctrl;
    logic                   w_idle;
    logic                   w_start;
    logic                   w_signed_mode;
    logic [DATA_W-1:0]      w_mag_a;
    logic [DATA_W-1:0]      w_mag_b;
    logic [PROD_W-1:0]      w_wb_val;
    logic                   w_unused;

    // Bus write decode; operand and mode writes are only legal while idle
    assign w_wr      = chipselect & ~write_n;
    assign w_idle    = (r_state == S_IDLE);
    assign w_wr_a    = w_wr & (address == C_ADDR_A) & w_idle;
    assign w_wr_b    = w_wr & (address == C_ADDR_B) & w_idle;
    assign w_wr_ctrl = w_wr & (address == C_ADDR_CTRL);
    assign w_start   = w_wr_ctrl & writedata[0] & w_idle;

    // Upper writedata bits are not stored for narrow operands
    assign w_unused  = &{1'b0, writedata};

`ifdef MUL_SEQ_SIGNED_EN
    logic r_signed_mode;
    logic r_sgn;
    logic w_mode_at_start;
    logic w_neg_a;
    logic w_neg_b;

    // The start write itself carries the mode bit, so it takes effect at once
    assign w_mode_at_start = writedata[2];
    assign w_neg_a         = w_mode_at_start & r_op_a[DATA_W-1];
    assign w_neg_b         = w_mode_at_start & r_op_b[DATA_W-1];
    // Negating the most negative value yields 2^(DATA_W-1), correct as unsigned
    assign w_mag_a         = w_neg_a ? (~r_op_a + 1'b1) : r_op_a;
    assign w_mag_b         = w_neg_b ? (~r_op_b + 1'b1) : r_op_b;
    assign w_wb_val        = r_sgn ? (~r_acc + 1'b1) : r_acc;
    assign w_signed_mode   = r_signed_mode;

    // Signed-mode register and the sign of the product latched at start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_signed_mode <= 1'b0;
            r_sgn         <= 1'b0;
        end else begin
            if (w_wr_ctrl && w_idle) begin
                r_signed_mode <= writedata[2];
            end
            if (w_start) begin
                r_sgn <= w_neg_a ^ w_neg_b;
            end
        end
    end
`else
    assign w_mag_a       = r_op_a;
    assign w_mag_b       = r_op_b;
    assign w_wb_val      = r_acc;
    assign w_signed_mode = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand registers, writable only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else begin
            if (w_wr_a) begin
                r_op_a <= writedata[DATA_W-1:0];
            end
            if (w_wr_b) begin
                r_op_b <= writedata[DATA_W-1:0];
            end
        end
    end

    // Interrupt enable is accepted in any state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_irq_en <= writedata[3];
        end
    end

    // Shift-add datapath: load at start, one partial product per RUN cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mcand  <= {{DATA_W{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Committed product; changes only on write-back so partial sums never show
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
        end else if (r_state == S_WB) begin
            r_result <= w_wb_val;
        end
    end

    // Done flag: write-back set beats any clear; start beats a same-write clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else if (r_state == S_WB) begin
            r_done <= 1'b1;
        end else if (w_start) begin
            r_done <= 1'b0;
        end else if (w_wr_ctrl && writedata[1]) begin
            r_done <= 1'b0;
        end
    end

    assign out_port = r_result;
    assign irq      = r_done & r_irq_en;

    // Combinational read mux of the addressed register
    always_comb begin
        readdata = 32'd0;
        case (address)
            C_ADDR_A:    readdata = 32'(r_op_a);
            C_ADDR_B:    readdata = 32'(r_op_b);
            C_ADDR_CTRL: readdata = {28'd0, r_irq_en, w_signed_mode, r_done, busy};
            C_ADDR_RES:  readdata = 32'(r_result);
            default:     readdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Self-checking bench for mul_seq_ctrl (DATA_W=16). Table of
//                multiply vectors plus hand sequences for mid-run writes,
//                reset, output hold and write-back collisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam int DATA_W = 16;
`ifdef MUL_SEQ_SIGNED_EN
    localparam bit C_SIGNED = 1'b1;
`else
    localparam bit C_SIGNED = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    wire  [31:0] readdata;
    wire  [31:0] out_port;
    wire         busy;
    wire         irq;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq_ctrl #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] ctrl;
        logic [31:0] exp_prod;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus write; returns 1 time unit after the edge that captured it
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input logic [1:0] a, input string name, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count cycles with busy high, bounded
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int cyc;
        logic [31:0] exp_stat;

        vecs[0] = '{16'h0003, 16'h0005, 32'h1, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'h9, 32'hFFFE0001};
        vecs[2] = '{16'h0007, 16'h0009, 32'h1, 32'h0000003F};
        vecs[3] = '{16'h1234, 16'h0010, 32'h1, 32'h00012340};
        vecs[4] = '{16'hFFFD, 16'h0005, 32'h5, C_SIGNED ? 32'hFFFFFFF1 : 32'h0004FFF1};
        vecs[5] = '{16'h8000, 16'h8000, 32'h5, 32'h40000000};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h5, C_SIGNED ? 32'hFFFFFFFF : 32'h0000FFFF};
        vecs[7] = '{16'h0000, 16'hABCD, 32'h1, 32'h00000000};

        // Reset state
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("rst_out_port", out_port, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        rd_check(2'd0, "rst_rd_a", 32'h0);
        rd_check(2'd2, "rst_rd_ctrl", 32'h0);
        rd_check(2'd3, "rst_rd_res", 32'h0);

        // Table-driven multiplies
        for (int i = 0; i < 8; i++) begin
            bus_wr(2'd0, {16'hDEAD, vecs[i].a});
            bus_wr(2'd1, {16'hBEEF, vecs[i].b});
            bus_wr(2'd2, vecs[i].ctrl);
            wait_idle(cyc);
            check($sformatf("v%0d_busy_cycles", i), cyc, 17);
            check($sformatf("v%0d_out_port", i), out_port, vecs[i].exp_prod);
            check($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].ctrl[3]});
            rd_check(2'd3, $sformatf("v%0d_rd_res", i), vecs[i].exp_prod);
            rd_check(2'd0, $sformatf("v%0d_rd_a", i), {16'd0, vecs[i].a});
            exp_stat = {28'd0, vecs[i].ctrl[3], C_SIGNED & vecs[i].ctrl[2], 1'b1, 1'b0};
            rd_check(2'd2, $sformatf("v%0d_rd_ctrl", i), exp_stat);
        end

        // Clear done with irq enabled: irq must drop
        bus_wr(2'd0, 32'hFFFF);
        bus_wr(2'd1, 32'hFFFF);
        bus_wr(2'd2, 32'h9);
        wait_idle(cyc);
        check("irq_set", {31'd0, irq}, 32'h1);
        bus_wr(2'd2, 32'h2);
        check("irq_clr", {31'd0, irq}, 32'h0);
        rd_check(2'd2, "done_clr", 32'h0);

        // Writes during RUN are ignored
        bus_wr(2'd0, 32'd7);
        bus_wr(2'd1, 32'd9);
        bus_wr(2'd2, 32'h1);
        tick(4);
        bus_wr(2'd0, 32'd2);
        bus_wr(2'd2, 32'h1);
        wait_idle(cyc);
        check("midrun_busy_cycles", cyc, 11);
        check("midrun_out_port", out_port, 32'h3F);
        rd_check(2'd0, "midrun_rd_a", 32'd7);
        tick(2);
        check("midrun_no_restart", {31'd0, busy}, 32'h0);

        // Asynchronous reset mid-operation
        bus_wr(2'd0, 32'd100);
        bus_wr(2'd1, 32'd200);
        bus_wr(2'd2, 32'h1);
        tick(7);
        reset_n = 1'b0;
        #1;
        check("arst_out_port", out_port, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        rd_check(2'd2, "arst_rd_ctrl", 32'h0);
        rd_check(2'd0, "arst_rd_a", 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        bus_wr(2'd0, 32'd4);
        bus_wr(2'd1, 32'd4);
        bus_wr(2'd2, 32'h1);
        wait_idle(cyc);
        check("post_rst_busy_cycles", cyc, 17);
        check("post_rst_out_port", out_port, 32'd16);

        // Back-to-back: previous product held through RUN and WB
        bus_wr(2'd0, 32'd2);
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd2, 32'h1);
        wait_idle(cyc);
        check("b2b_first", out_port, 32'd6);
        bus_wr(2'd0, 32'd0);
        bus_wr(2'd1, 32'hABCD);
        bus_wr(2'd2, 32'h1);
        rd_check(2'd2, "b2b_done_cleared", 32'h1);
        tick(8);
        check("b2b_hold_run", out_port, 32'd6);
        tick(8);
        check("b2b_hold_wb", {31'd0, busy}, 32'h1);
        check("b2b_hold_wb_out", out_port, 32'd6);
        tick(1);
        check("b2b_second", out_port, 32'd0);
        rd_check(2'd2, "b2b_done_again", 32'h2);

        // Done-clear in the WB cycle loses to the set
        bus_wr(2'd0, 32'd5);
        bus_wr(2'd1, 32'd5);
        bus_wr(2'd2, 32'h1);
        tick(16);
        bus_wr(2'd2, 32'h2);
        rd_check(2'd2, "wb_clear_loses", 32'h2);
        check("wb_clear_out", out_port, 32'd25);

        // Start in the WB cycle is dropped
        bus_wr(2'd0, 32'd6);
        bus_wr(2'd1, 32'd6);
        bus_wr(2'd2, 32'h1);
        tick(16);
        bus_wr(2'd2, 32'h1);
        check("wb_start_dropped", {31'd0, busy}, 32'h0);
        tick(1);
        check("wb_start_still_idle", {31'd0, busy}, 32'h0);
        check("wb_start_out", out_port, 32'd36);

        // CTRL bit2 readback
        bus_wr(2'd2, 32'h4);
        rd_check(2'd2, "ctrl_bit2", C_SIGNED ? 32'h6 : 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Avalon-MM slave controller that sequences an iterative shift-add multiplier for the Nios II system.
- Software loads operands A and B, then writes a start command.
- The block runs one partial-product step per clock.
- The product is committed to a held output register that drives out_port, the same parallel output the mul_out PIO presents.
- Busy/done status and an optional interrupt let the CPU poll or sleep.

Parameters:
DATA_W, 16, operand width in bits; product width is 2*DATA_W; legal range 2..16 so the product fits in readdata.

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
address  input  2  register select: 0=A, 1=B, 2=CTRL/STATUS, 3=RESULT
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  32  write data
readdata  output  32  combinational read mux of the addressed register
out_port  output  2*DATA_W  committed product register
busy  output  1  high while a multiply is in progress
irq  output  1  done AND irq_en

Behaviour:
- Reset: all of the following are 0 and state=IDLE:
  - op_a, op_b, acc, mcand, mplier, cnt, result/out_port
  - done, irq_en, busy, irq
  - readdata is a function of the registers and address only.
- Write decode: wr = chipselect & ~write_n.
  - addr0: op_a <= writedata[DATA_W-1:0]. addr1: op_b <= writedata[DATA_W-1:0]. Both are ignored while state != IDLE.
  - addr2, always accepted:
    - bit3 -> irq_en.
    - bit1=1 clears done.
    - bit0=1 issues start; honoured only in IDLE, silently dropped otherwise.
  - addr3: write ignored.
- Read mux:
  - addr0 = op_a zero-extended; addr1 = op_b zero-extended.
  - addr2 = {28'b0, irq_en, signed_mode, done, busy}.
  - addr3 = result zero-extended.
- FSM IDLE -> RUN -> WB -> IDLE:
  - IDLE: on accepted start edge E0:
    - mcand <= op_a zero-extended to 2*DATA_W; mplier <= op_b; acc <= 0; cnt <= 0.
    - done <= 0, and start overrides a same-write bit1.
    - go to RUN.
  - RUN, each edge:
    - acc <= acc + (mplier[0] ? mcand : 0); mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
    - After DATA_W RUN edges (E1..E_DATA_W, cnt==DATA_W-1 on the last one) go to WB.
  - WB, edge E_(DATA_W+1): result <= acc (out_port updates); done <= 1; go to IDLE.
- Status timing:
  - busy = (state != IDLE); it is high from the cycle after E0 through the WB cycle.
  - Total latency from start edge to out_port valid: DATA_W+1 clocks.
- Arithmetic: unsigned, modulo 2^(2*DATA_W); overflow is impossible.
- out_port holds its previous product during RUN; it never shows partial sums.
- Simultaneous events:
  - A done-clear write in the same cycle as WB: the set wins, done=1.
  - A start in the same cycle WB returns to IDLE is dropped, because state is still WB.
- Reset mid-operation returns everything to the reset values; out_port reads 0.

Optional Feature:
MUL_SEQ_SIGNED_EN
- Defined:
  - CTRL bit2 is a writable signed_mode register, accepted only in IDLE, reset 0.
  - When signed_mode=1 at start:
    - operands are treated as two's complement;
    - the magnitudes |A| and |B| are loaded into mcand/mplier;
    - the sign flag sgn = A[msb]^B[msb] is latched;
    - in WB, result <= sgn ? -acc : acc.
  - Latency is unchanged.
  - The most negative value is handled correctly: its magnitude 2^(DATA_W-1) fits the 2*DATA_W datapath.
- Undefined: CTRL bit2 reads 0, writes are ignored, and the path is unsigned only.

Test Plan:
1. DATA_W=16, reset, A=3, B=5, start -> busy=1 for 17 cycles; out_port=0x0000000F at E17; done=1; readdata@3=0xF; irq stays 0 because irq_en=0.
2. A=0xFFFF, B=0xFFFF, CTRL=0x9 (start+irq_en) -> out_port=0xFFFE0001 and irq=1 after 17 clocks; then write CTRL=0x2 -> done=0, irq=0.
3. Start 7*9; at E5 write A=2 and CTRL start -> both ignored; out_port=63 (0x3F); readdata@0 still 7.
4. Start 100*200; assert reset_n=0 at E8 -> out_port=0, busy=0, done=0, readdata@0=0; after release, 4*4 completes normally to 16.
5. Back-to-back runs: 2*3 done, immediately start 0*0xABCD -> out_port holds 6 through RUN, then becomes 0 at WB; done rises again.
6. With MUL_SEQ_SIGNED_EN: A=0xFFFD (-3), B=5, CTRL=0x5 -> out_port=0xFFFFFFF1; A=0x8000, B=0x8000 -> 0x40000000. Without the macro, the same stimulus gives 0x0004FFF1, and CTRL bit2 reads 0.
